rand_collector: RTL and testbench
=================================

RAND_COLLECTOR -- requirements
Module: rand_collector

Interface
REQ-001 Parameter WIDTH, default 8: width of one random sample.
REQ-002 Parameter DEPTH, default 4: sample buffer entries; SHALL be a power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent in WAIT before the burst is aborted.
REQ-004 Port clk  in  1: single clock; all state SHALL change on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-low.
REQ-006 Port req  in  1: burst request, sampled only in IDLE.
REQ-007 Port req_count  in  4: number of samples in the burst, latched with req.
REQ-008 Port gen_start  out  1: start pulse to the random-generator controller.
REQ-009 Port gen_done  in  1: completion pulse from the generator controller.
REQ-010 Port gen_data  in  WIDTH: generator output word, valid while gen_done=1.
REQ-011 Port out_valid  out  1: buffer non-empty.
REQ-012 Port out_ready  in  1: consumer accepts the head sample.
REQ-013 Port out_data  out  WIDTH: head sample of the buffer.
REQ-014 Port busy  out  1: high in every state except IDLE.
REQ-015 Port burst_done  out  1: one-cycle pulse, burst completed.
REQ-016 Port err_timeout  out  1: one-cycle pulse, burst aborted on timeout.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, START, WAIT.
REQ-018 IDLE with req=1 and req_count!=0: latch remaining=req_count, go to START.
REQ-019 IDLE with req=1 and req_count=0: stay in IDLE, pulse burst_done on the next cycle.
REQ-020 req outside IDLE SHALL be ignored, with no latching and no queuing.
REQ-021 START with buffer count<DEPTH: gen_start=1 for that cycle only, clear timer, go to WAIT next cycle.
REQ-022 START with buffer full: gen_start=0, remain in START (stall); no sample is ever dropped.
REQ-023 WAIT with gen_done=1: push gen_data into the buffer at that edge, decrement remaining.
  - Remaining becomes 0: go to IDLE, burst_done=1 on the following cycle.
  - Otherwise: go to START.
REQ-024 WAIT with gen_done=0: increment the 4-bit timer.
  - Timer equals TIMEOUT: go to IDLE, err_timeout=1 next cycle, remaining cleared.
  - Samples already buffered are retained.
REQ-025 gen_done in IDLE or START SHALL be ignored, with no push.
REQ-026 Latency: req sampled at edge N gives gen_start=1 in cycle N+1 (buffer not full).
REQ-027 Latency: gen_done at edge M gives out_valid=1 from cycle M+1 when the buffer was empty.
REQ-028 The buffer SHALL be a circular FIFO with log2(DEPTH)-bit read/write pointers that wrap to 0 after DEPTH-1, plus a count of width log2(DEPTH)+1.
REQ-029 Pop SHALL occur when out_valid=1 and out_ready=1; out_data is the head entry, combinational from the buffer.
REQ-030 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing.
REQ-031 Pop when empty SHALL have no effect.
REQ-032 Push when full cannot occur by construction (REQ-022).
REQ-033 burst_done and err_timeout SHALL never be high in the same cycle and SHALL each last exactly one cycle.

Reset
REQ-034 rst=0 SHALL, asynchronously, force state IDLE and clear remaining, timer, pointers and count.
REQ-035 During reset, all outputs SHALL be 0: gen_start, out_valid, busy, burst_done, err_timeout; out_data=0.
REQ-036 Reset mid-burst SHALL discard buffered samples and the in-flight request.
REQ-037 The first req SHALL be honoured on the first rising edge after rst returns to 1.

Verification
REQ-038 Basic burst:
  - Stimulus: req, req_count=3; generator answers gen_done 4 cycles after each gen_start with data 0x11, 0x22, 0x33; out_ready=1.
  - Response: three gen_start pulses; out_data 0x11, 0x22, 0x33 in order; burst_done once.
REQ-039 Backpressure:
  - Stimulus: req_count=6; out_ready=0.
  - Response: exactly 4 gen_start pulses, then START stall with busy=1.
  - Then: out_ready=1 resumes; 6 samples total, in order.
REQ-040 Timeout:
  - Stimulus: req_count=2; gen_done never asserted.
  - Response: err_timeout pulses 16 cycles after gen_start; busy=0; no burst_done.
REQ-041 Zero count:
  - Stimulus: req, req_count=0.
  - Response: no gen_start; burst_done pulse next cycle; busy stays 0.
REQ-042 Reset mid-burst:
  - Stimulus: rst=0 with 2 samples buffered and in WAIT.
  - Response: out_valid=0 and busy=0 immediately, without a clock edge; a later req_count=1 burst works normally.
REQ-043 Wrap and spurious done:
  - Stimulus: 10 single-sample bursts with interleaved pops; gen_done in IDLE.
  - Response: pointers wrap, order preserved; spurious gen_done causes no push.

Source files
------------

// File: rtl/rand_collector.sv
// rand_collector: runs bursts of random-generator requests and
// collects the returned words in a small circular FIFO.
module rand_collector #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [3:0]       req_count,
  output logic             gen_start,
  input  logic             gen_done,
  input  logic [WIDTH-1:0] gen_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             burst_done,
  output logic             err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [3:0]  TMO_C  = 4'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_e;

  state_e           state_q;
  logic [3:0]       rem_q;
  logic [3:0]       timer_q;
  logic [3:0]       timer_d;
  logic             done_q;
  logic             tmo_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rptr_q;
  logic [AW-1:0]    wptr_q;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  logic             full;
  logic             push;
  logic             pop;

  assign full        = (cnt_q == FULL_C);
  assign push        = (state_q == WAIT) && gen_done;
  assign pop         = out_valid && out_ready;
  assign timer_d     = timer_q + 4'd1;
  assign gen_start   = (state_q == START) && !full;
  assign busy        = (state_q != IDLE);
  assign burst_done  = done_q;
  assign err_timeout = tmo_q;
  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? mem_q[rptr_q] : '0;

  // Burst sequencing: accept request, pulse start, await done or timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      timer_q <= '0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (req_count != 4'd0) begin
              rem_q   <= req_count;
              state_q <= START;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        START: begin
          if (!full) begin
            timer_q <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (gen_done) begin
            rem_q <= rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              state_q <= START;
            end
          end else begin
            timer_q <= timer_d;
            if (timer_d == TMO_C) begin
              state_q <= IDLE;
              rem_q   <= '0;
              tmo_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Occupancy next-state; push with pop leaves count unchanged
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Read/write pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Sample storage, written only on a push
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= gen_data;
  end

endmodule

// File: tb/tb_rand_collector.sv
// tb_rand_collector: randomized bench for rand_collector with a
// queue-based reference of generator words and consumer pops.
`timescale 1ns/1ps
module tb_rand_collector;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req = 1'b0;
  logic [3:0]   req_count = '0;
  logic         gen_start;
  logic         gen_done = 1'b0;
  logic [W-1:0] gen_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         busy;
  logic         burst_done;
  logic         err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  int n_start, n_done, n_err, n_both;
  int cd, lat_lo, lat_hi, rdy_pct;
  bit gen_en, spur;
  logic [W-1:0] pend;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] src_q[$];

  rand_collector #(
    .WIDTH(W),
    .DEPTH(4),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_count(req_count),
    .gen_start(gen_start),
    .gen_done(gen_done),
    .gen_data(gen_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .burst_done(burst_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    src_q.delete();
    n_start = 0;
    n_done  = 0;
    n_err   = 0;
    n_both  = 0;
    cd      = 0;
    spur    = 1'b0;
    gen_en  = 1'b1;
  endtask

  // One cycle: act as generator and consumer, record observations
  task automatic tick();
    @(negedge clk);
    gen_done = 1'b0;
    gen_data = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        gen_done = 1'b1;
        gen_data = pend;
        exp_q.push_back(pend);
      end
    end
    if (spur) begin
      gen_done = 1'b1;
      gen_data = 8'hEE;
      spur = 1'b0;
    end
    if (gen_start) begin
      n_start++;
      if (gen_en) begin
        cd = int'($urandom_range(lat_hi, lat_lo));
        if (src_q.size() > 0) pend = src_q.pop_front();
        else pend = W'($urandom);
      end
    end
    out_ready = (int'($urandom_range(99)) < rdy_pct);
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (burst_done) n_done++;
    if (err_timeout) n_err++;
    if (burst_done && err_timeout) n_both++;
  endtask

  task automatic wait_done(input int target, input int budget,
                           output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    rdy_pct = 100;
    lat_lo = 2;
    lat_hi = 2;
    rst = 1'b0;
    req = 1'b1;
    req_count = 4'd3;
    tick();
    tick();
    n_cmp++;
    if ({gen_start, out_valid, busy, burst_done, err_timeout} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {gen_start, out_valid, busy, burst_done, err_timeout});
    end
    n_cmp++;
    if (out_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 00", out_data);
    end
    req = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || gen_start !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy %b gs %b want 0 0", busy, gen_start);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_model();
    rdy_pct = 100;
    lat_lo = 4;
    lat_hi = 4;
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    req = 1'b1;
    req_count = 4'd3;
    tick();
    req = 1'b0;
    n_cmp++;
    if (gen_start !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_latency: gen_start %b want 1", gen_start);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gen_done) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    n_cmp++;
    if (!ok || out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_bad++;
      $display("FAIL basic_valid_lat: ok %b valid %b data %h want 1 1 11",
               ok, out_valid, out_data);
    end
    wait_done(1, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL basic_done: got none want 1");
    end
    for (int i = 0; i < 4; i++) tick();
    n_cmp++;
    if (n_start != 3 || n_done != 1 || n_err != 0) begin
      n_bad++;
      $display("FAIL basic_counts: start %0d done %0d err %0d want 3 1 0",
               n_start, n_done, n_err);
    end
    n_cmp++;
    if (got_q.size() != 3) begin
      n_bad++;
      $display("FAIL basic_size: got %0d want 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_model();
    rdy_pct = 0;
    lat_lo = 1;
    lat_hi = 5;
    req = 1'b1;
    req_count = 4'd6;
    tick();
    req = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    n_cmp++;
    if (n_start != 4 || gen_start !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_stall: start %0d gs %b busy %b want 4 0 1",
               n_start, gen_start, busy);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || got_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_hold: valid %b pops %0d want 1 0",
               out_valid, got_q.size());
    end
    rdy_pct = 100;
    wait_done(1, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL bp_done: got none want 1");
    end
    for (int i = 0; i < 6; i++) tick();
    n_cmp++;
    if (got_q.size() != 6 || exp_q.size() != 6 || n_start != 6) begin
      n_bad++;
      $display("FAIL bp_size: got %0d sent %0d starts %0d want 6 6 6",
               got_q.size(), exp_q.size(), n_start);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int early;
    clear_model();
    gen_en = 1'b0;
    rdy_pct = 100;
    req = 1'b1;
    req_count = 4'd2;
    tick();
    req = 1'b0;
    n_cmp++;
    if (gen_start !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_start: gen_start %b want 1", gen_start);
    end
    early = 0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (err_timeout !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_bad++;
      $display("FAIL tmo_early: bad cycles %0d want 0", early);
    end
    tick();
    n_cmp++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || burst_done !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_pulse: err %b busy %b done %b want 1 0 0",
               err_timeout, busy, burst_done);
    end
    tick();
    n_cmp++;
    if (err_timeout !== 1'b0 || n_done != 0 || n_start != 1) begin
      n_bad++;
      $display("FAIL tmo_after: err %b done %0d starts %0d want 0 0 1",
               err_timeout, n_done, n_start);
    end
    gen_en = 1'b1;
  endtask

  task automatic test_zero();
    clear_model();
    rdy_pct = 100;
    req = 1'b1;
    req_count = 4'd0;
    tick();
    req = 1'b0;
    n_cmp++;
    if (burst_done !== 1'b1 || busy !== 1'b0 || gen_start !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_pulse: done %b busy %b gs %b want 1 0 0",
               burst_done, busy, gen_start);
    end
    tick();
    tick();
    n_cmp++;
    if (burst_done !== 1'b0 || n_done != 1 || n_start != 0) begin
      n_bad++;
      $display("FAIL zero_after: done %b cnt %0d starts %0d want 0 1 0",
               burst_done, n_done, n_start);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_model();
    rdy_pct = 0;
    lat_lo = 3;
    lat_hi = 3;
    req = 1'b1;
    req_count = 4'd3;
    tick();
    req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (exp_q.size() == 2 && n_start == 3) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    n_cmp++;
    if (!ok || out_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_setup: ok %b valid %b busy %b want 1 1 1",
               ok, out_valid, busy);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || gen_start !== 1'b0
        || out_data !== 8'h00) begin
      n_bad++;
      $display("FAIL rmid_async: valid %b busy %b gs %b data %h want 0 0 0 00",
               out_valid, busy, gen_start, out_data);
    end
    clear_model();
    gen_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy_pct = 100;
    src_q.push_back(8'h5A);
    req = 1'b1;
    req_count = 4'd1;
    tick();
    req = 1'b0;
    n_cmp++;
    if (gen_start !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_first_req: gen_start %b want 1", gen_start);
    end
    wait_done(1, 100, ok);
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (!ok || got_q.size() != 1 || n_start != 1) begin
      n_bad++;
      $display("FAIL rmid_burst: ok %b pops %0d starts %0d want 1 1 1",
               ok, got_q.size(), n_start);
    end
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      n_bad++;
      $display("FAIL rmid_data: got %h want 5a",
               got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int miss;
    clear_model();
    rdy_pct = 50;
    lat_lo = 1;
    lat_hi = 4;
    miss = 0;
    for (int b = 0; b < 10; b++) begin
      spur = 1'b1;
      req = 1'b1;
      req_count = 4'd1;
      tick();
      req = 1'b0;
      wait_done(b + 1, 80, ok);
      if (!ok) miss++;
      spur = 1'b1;
      tick();
    end
    n_cmp++;
    if (miss != 0) begin
      n_bad++;
      $display("FAIL wrap_done: missing %0d want 0", miss);
    end
    rdy_pct = 100;
    for (int i = 0; i < 10; i++) tick();
    n_cmp++;
    if (got_q.size() != 10 || exp_q.size() != 10 || n_start != 10) begin
      n_bad++;
      $display("FAIL wrap_size: got %0d sent %0d starts %0d want 10 10 10",
               got_q.size(), exp_q.size(), n_start);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_empty: valid %b want 0", out_valid);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int total;
    int miss;
    int c;
    clear_model();
    rdy_pct = 70;
    lat_lo = 1;
    lat_hi = 6;
    total = 0;
    miss = 0;
    for (int b = 0; b < 12; b++) begin
      c = int'($urandom_range(15, 0));
      if (b == 3) c = 0;
      total += c;
      req = 1'b1;
      req_count = 4'(c);
      tick();
      req = 1'b0;
      wait_done(b + 1, 300, ok);
      if (!ok) miss++;
    end
    rdy_pct = 100;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (miss != 0 || n_done != 12 || n_err != 0 || n_both != 0) begin
      n_bad++;
      $display("FAIL b2b_flags: miss %0d done %0d err %0d both %0d want 0 12 0 0",
               miss, n_done, n_err, n_both);
    end
    n_cmp++;
    if (n_start != total || got_q.size() != total) begin
      n_bad++;
      $display("FAIL b2b_count: starts %0d pops %0d want %0d",
               n_start, got_q.size(), total);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL b2b_data[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    clear_model();
    lat_lo = 1;
    lat_hi = 1;
    rdy_pct = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_zero();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
